input_debounce_filter: RTL and testbench

Per-bit digital debounce and glitch filter for the satellite's raw input pins. Sits directly upstream of the latch register. Its debounced outputs drive the latch register's latch inputs, so only stable edges are latched. Sampling is tick-based off masterClk, so the filter time is set by parameters and not by clock frequency alone.

---
 rtl/input_debounce_filter.sv | 86 ++++++++
 tb/tb_input_debounce_filter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/input_debounce_filter.sv
// Per-bit debounce/glitch filter for raw satellite input pins.
// Two-flop sync, free-running sample prescaler, per-bit run-length counters.
module input_debounce_filter #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned PRESCALE     = 3000,
  parameter int unsigned FILTER_TICKS = 4
) (
  input  logic             masterClk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rawInput,
  input  logic             filterEnable,
  output logic [WIDTH-1:0] debouncedOutput,
  output logic [WIDTH-1:0] changeStrobe
);

  localparam int unsigned PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned CNT_W = $clog2(FILTER_TICKS) + 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_TICKS - 1);

  logic [WIDTH-1:0]            meta_q, meta_d;
  logic [WIDTH-1:0]            sync_q, sync_d;
  logic [PS_W-1:0]             ps_q, ps_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            dbnc_q, dbnc_d;
  logic [WIDTH-1:0]            strb_q, strb_d;
  logic                        tick_c;

  // Synchronizer for asynchronous pins; only sync_q is used downstream.
  always_comb begin
    meta_d = rawInput;
    sync_d = meta_q;
  end

  // Free-running sample prescaler, independent of filterEnable.
  always_comb begin
    tick_c = (ps_q == PS_LAST);
    ps_d   = tick_c ? '0 : ps_q + PS_W'(1);
  end

  // Per-bit filter: flip after FILTER_TICKS consecutive differing samples.
  always_comb begin
    dbnc_d = dbnc_q;
    strb_d = '0;
    cnt_d  = cnt_q;
    if (!filterEnable) begin
      dbnc_d = sync_q;
      strb_d = sync_q ^ dbnc_q;
      cnt_d  = '0;
    end else if (tick_c) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (sync_q[i] == dbnc_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          dbnc_d[i] = sync_q[i];
          strb_d[i] = 1'b1;
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge masterClk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      ps_q   <= '0;
      cnt_q  <= '0;
      dbnc_q <= '0;
      strb_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      ps_q   <= ps_d;
      cnt_q  <= cnt_d;
      dbnc_q <= dbnc_d;
      strb_q <= strb_d;
    end
  end

  assign debouncedOutput = dbnc_q;
  assign changeStrobe    = strb_q;

endmodule

// File: tb/tb_input_debounce_filter.sv
// Bench for input_debounce_filter: directed scenarios plus random stimulus,
// every cycle compared against a sample-count reference model.
module tb_input_debounce_filter;

  localparam int unsigned W  = 8;
  localparam int unsigned P  = 4;
  localparam int unsigned FT = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] raw;
  logic         en;
  logic [W-1:0] dout;
  logic [W-1:0] strb;

  always #5 clk = ~clk;

  input_debounce_filter #(.WIDTH(W), .PRESCALE(P), .FILTER_TICKS(FT)) dut (
    .masterClk       (clk),
    .reset           (rst),
    .rawInput        (raw),
    .filterEnable    (en),
    .debouncedOutput (dout),
    .changeStrobe    (strb)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: pin history, cycles since reset, per-bit run of differing samples.
  logic [W-1:0] m_hist0, m_hist1, m_out, m_strb;
  int           m_cycles;
  int           m_run [W];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one clock edge to the model using the inputs present before the edge.
  task automatic model_edge();
    logic [W-1:0] seen;
    bit           sample;
    if (rst) begin
      m_hist0 = '0; m_hist1 = '0; m_out = '0; m_strb = '0; m_cycles = 0;
      for (int i = 0; i < int'(W); i++) m_run[i] = 0;
    end else begin
      seen   = m_hist1;
      sample = ((m_cycles % int'(P)) == int'(P) - 1);
      m_strb = '0;
      if (!en) begin
        m_strb = seen ^ m_out;
        m_out  = seen;
        for (int i = 0; i < int'(W); i++) m_run[i] = 0;
      end else if (sample) begin
        for (int i = 0; i < int'(W); i++) begin
          if (seen[i] == m_out[i]) m_run[i] = 0;
          else begin
            m_run[i]++;
            if (m_run[i] == int'(FT)) begin
              m_out[i]  = seen[i];
              m_strb[i] = 1'b1;
              m_run[i]  = 0;
            end
          end
        end
      end
      m_cycles++;
      m_hist1 = m_hist0;
      m_hist0 = raw;
    end
  endtask

  // Drive inputs at the negedge, clock once, then compare at the next negedge.
  task automatic step(input logic [W-1:0] r, input logic e, input logic rs);
    raw = r; en = e; rst = rs;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("model_dout", 32'(dout), 32'(m_out));
    check("model_strb", 32'(strb), 32'(m_strb));
  endtask

  int           lat, pulses, bad;
  logic [W-1:0] r;
  logic         e;

  initial begin
    raw = '0; en = 1'b1; rst = 1'b1;
    @(negedge clk);

    // Reset with all pins high
    step(8'hFF, 1'b1, 1'b1);
    check("rst_dout", 32'(dout), 32'h0);
    step(8'hFF, 1'b1, 1'b1);
    check("rst_strb", 32'(strb), 32'h0);
    step(8'hFF, 1'b1, 1'b0);
    check("post_rst_dout", 32'(dout), 32'h0);
    check("post_rst_strb", 32'(strb), 32'h0);

    // Clean step on bit 0
    step(8'h00, 1'b1, 1'b1);
    for (int k = 0; k < 20; k++) step(8'h00, 1'b1, 1'b0);
    lat = 0; pulses = 0;
    for (int k = 1; k <= 30; k++) begin
      step(8'h01, 1'b1, 1'b0);
      if (strb != 0) begin
        pulses++;
        check("step_strb_val", 32'(strb), 32'h01);
      end
      if (dout[0] && lat == 0) lat = k;
    end
    check("step_latency_ok", 32'(lat >= 1 && lat <= 15), 32'h1);
    check("step_pulses", 32'(pulses), 32'h1);
    check("step_dout", 32'(dout), 32'h01);

    // Glitch rejection at every prescaler phase
    for (int ph = 0; ph < int'(P); ph++) begin
      for (int k = 0; k < ph + 8; k++) step(8'h01, 1'b1, 1'b0);
      bad = 0;
      for (int k = 0; k < 8; k++) begin
        step(8'h09, 1'b1, 1'b0);
        if (dout[3] || strb[3]) bad++;
      end
      for (int k = 0; k < 20; k++) begin
        step(8'h01, 1'b1, 1'b0);
        if (dout[3] || strb[3]) bad++;
      end
      check("glitch_rejected", 32'(bad), 32'h0);
    end

    // Bounce on bit 5 then hold high
    r = 8'h01; bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (k % 3 == 0) r[5] = ~r[5];
      step(r, 1'b1, 1'b0);
      if (strb[5] || dout[5]) bad++;
    end
    check("bounce_quiet", 32'(bad), 32'h0);
    lat = 0; pulses = 0;
    for (int k = 1; k <= 30; k++) begin
      step(8'h21, 1'b1, 1'b0);
      if (strb[5]) begin
        pulses++;
        if (lat == 0) lat = k;
      end
    end
    check("bounce_pulses", 32'(pulses), 32'h1);
    check("bounce_latency_ok", 32'(lat >= 1 && lat <= 15), 32'h1);

    // Bypass: exact 3-cycle latency and simultaneous strobes
    for (int k = 0; k < 6; k++) step(8'h00, 1'b0, 1'b0);
    check("byp_settle", 32'(dout), 32'h00);
    step(8'hA5, 1'b0, 1'b0);
    check("byp_c1", 32'(dout), 32'h00);
    step(8'hA5, 1'b0, 1'b0);
    check("byp_c2", 32'(dout), 32'h00);
    step(8'hA5, 1'b0, 1'b0);
    check("byp_c3_dout", 32'(dout), 32'hA5);
    check("byp_c3_strb", 32'(strb), 32'hA5);
    step(8'hA5, 1'b0, 1'b0);
    check("byp_c4_strb", 32'(strb), 32'h00);

    // Reset mid-filter discards the partial count on bit 1
    step(8'h00, 1'b1, 1'b1);
    for (int k = 0; k < 9; k++) step(8'h02, 1'b1, 1'b0);
    check("midrst_before", 32'(dout), 32'h00);
    step(8'h02, 1'b1, 1'b1);
    check("midrst_during", 32'(dout), 32'h00);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step(8'h02, 1'b1, 1'b0);
      if (dout[1] && lat == 0) lat = k;
    end
    check("midrst_latency", 32'(lat), 32'd12);

    // Random pins, enable toggles and occasional resets
    r = '0; e = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 5) == 0) r = r ^ W'($urandom);
      if ($urandom_range(0, 150) == 0) e = ~e;
      step(r, e, ($urandom_range(0, 700) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
